alu_io_sequencer: RTL and testbench
===================================

// Module: alu_io_sequencer
// PURPOSE
//  Bus-side companion of the one-hot ALU control unit. Accepts an operation request
//  over a valid/ready handshake and pulses BEGIN. Drives INBUS with the operand matching
//  each load strobe from the control unit. Captures OUTBUS after each push strobe.
//  Returns the A/Q result words to the requester over a second valid/ready handshake.
// PARAMETERS
//  WIDTH        8    datapath width of INBUS/OUTBUS and A, Q, M registers
//  WDOG_CYCLES  255  max RUN cycles before timeout (used only with watchdog macro)
// PORTS
//  clk                      in   1      single clock, rising edge
//  reset                    in   1      asynchronous, active-low reset
//  req_valid                in   1      request offered
//  req_ready                out  1      sequencer can accept a request
//  req_op                   in   2      00 add, 01 sub, 10 mul, 11 div
//  req_a, req_q, req_m      in   WIDTH  operands for A, Q, M registers
//  rsp_valid                out  1      result available
//  rsp_ready                in   1      requester takes result
//  rsp_a, rsp_q             out  WIDTH  captured A / Q words
//  rsp_err                  out  1      watchdog timeout flag (0 without macro)
//  BEGIN                    out  1      start pulse to control unit
//  op_code                  out  2      held operation code to control unit
//  loadA_in, loadQ_in, loadM_in  in 1   control-unit load strobes
//  pushA_in, pushQ_in       in   1      control-unit push strobes
//  END                      in   1      control-unit completion
//  INBUS                    out  WIDTH  operand bus to datapath
//  OUTBUS                   in   WIDTH  result bus from datapath
//  busy                     out  1      state != IDLE
// BEHAVIOUR
//  - Reset values: state IDLE; rsp_a, rsp_q, op_code all 0; rsp_valid, rsp_err, BEGIN all 0.
//  - Only req_ready = 1 out of reset.
//  - FSM states IDLE, START, RUN, RESP:
//    - IDLE, req_ready=1: on req_valid, latch req_op and the three operands, clear
//      rsp_a/rsp_q/rsp_err, then go to START.
//    - START: BEGIN=1 for exactly one cycle, then go to RUN.
//    - RUN: wait for END=1, then go to RESP.
//    - RESP: rsp_valid=1, outputs held stable; on rsp_ready, go to IDLE.
//  - op_code = latched op from accept until return to IDLE; 0 in IDLE.
//  - INBUS is combinational and valid only in RUN:
//    - loadA_in selects the latched A operand; loadQ_in selects Q; loadM_in selects M.
//    - Priority A > Q > M. INBUS = 0 when no strobe.
//    - Strobes lead the register load edge, so INBUS must be valid in the same cycle.
//  - Push strobes are registered one cycle. OUTBUS is sampled in the cycle after pushX_in:
//    - rsp_a <= OUTBUS when pushA_d is high; rsp_q <= OUTBUS when pushQ_d is high.
//    - Push order is free: mul pushes A then Q; div pushes Q then A; add/sub push A only,
//      so rsp_q stays 0.
//  - END coincides with the final capture cycle. Capture and the RUN->RESP transition happen
//    on the same edge. rsp_valid rises the cycle after END.
//  - Ignored: END, load and push strobes outside RUN. req_valid outside IDLE is not accepted.
//  - Back-to-back: at least one idle cycle between a RESP handshake and the next accept.
//  - Reset mid-operation clears everything asynchronously. The system must reset the control
//    unit on the same reset.
// CONFIGURATION
//  ALU_IO_WATCHDOG_EN defined:
//    - A RUN-cycle counter is cleared on entry to RUN.
//    - If WDOG_CYCLES elapse without END, go to RESP with rsp_err=1 and rsp_a = rsp_q = 0.
//    - A late END after timeout is ignored.
//  ALU_IO_WATCHDOG_EN undefined: no counter, rsp_err tied 0, RUN waits indefinitely.
// TESTING (WIDTH=8, bench models control-unit strobe timing)
//  1. add, a=0x25, m=0x13 -> INBUS=0x25 on loadA, 0x13 on loadM;
//     rsp_a=0x38, rsp_q=0x00, rsp_err=0.
//  2. mul, q=0x07, m=0x06 -> INBUS=0x07 on loadQ; pushes A then Q; rsp_a=0x00, rsp_q=0x2A.
//  3. div, a=0x00, q=0x64, m=0x07 -> pushes Q then A; rsp_q=0x0E, rsp_a=0x02.
//  4. rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_a, rsp_q stable;
//     req_ready=0; no second BEGIN.
//  5. reset low during RUN after loadQ -> immediately IDLE, req_ready=1, all outputs at
//     reset values.
//  6. WDOG_CYCLES=16 with macro, END never asserted -> rsp_valid=1 and rsp_err=1 on the
//     17th cycle after BEGIN.

Source files
------------

// File: rtl/alu_io_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_io_sequencer_if
//  Description : Bundle of the request/response handshakes and the control-
//                unit / datapath bus signals of the ALU I/O sequencer.
//                slave  = the sequencer itself, master = its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_io_sequencer_if #(
    parameter int WIDTH = 8
);
    // Requester side
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] req_m;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_a;
    logic [WIDTH-1:0] rsp_q;
    logic             rsp_err;

    // Control unit / datapath side
    logic             BEGIN;
    logic [1:0]       op_code;
    logic             loadA_in;
    logic             loadQ_in;
    logic             loadM_in;
    logic             pushA_in;
    logic             pushQ_in;
    logic             END;
    logic [WIDTH-1:0] INBUS;
    logic [WIDTH-1:0] OUTBUS;
    logic             busy;

    modport slave (
        input  req_valid, req_op, req_a, req_q, req_m, rsp_ready,
        input  loadA_in, loadQ_in, loadM_in, pushA_in, pushQ_in, END, OUTBUS,
        output req_ready, rsp_valid, rsp_a, rsp_q, rsp_err,
        output BEGIN, op_code, INBUS, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_q, req_m, rsp_ready,
        output loadA_in, loadQ_in, loadM_in, pushA_in, pushQ_in, END, OUTBUS,
        input  req_ready, rsp_valid, rsp_a, rsp_q, rsp_err,
        input  BEGIN, op_code, INBUS, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_io_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_io_sequencer
//  Description : Bus-side companion of the one-hot ALU control unit. Accepts
//                an operation request, pulses BEGIN, feeds operands onto
//                INBUS on the load strobes, captures OUTBUS after the push
//                strobes and returns the A/Q words to the requester.
//                Optional RUN watchdog: define ALU_IO_WATCHDOG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_io_sequencer #(
    parameter int WIDTH       = 8,
    parameter int WDOG_CYCLES = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,   // asynchronous, active low
    alu_io_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op_code;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_rsp_a;
    logic [WIDTH-1:0] r_rsp_q;
    logic             r_push_a_d;
    logic             r_push_q_d;
    logic [WIDTH-1:0] w_inbus;

`ifdef ALU_IO_WATCHDOG_EN
    localparam int C_WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [C_WDOG_W-1:0] r_wdog_cnt;
    logic                r_rsp_err;
`endif

    // Sequencer FSM: request accept, BEGIN pulse, RUN with result capture, response hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op_code  <= 2'd0;
            r_a        <= '0;
            r_q        <= '0;
            r_m        <= '0;
            r_rsp_a    <= '0;
            r_rsp_q    <= '0;
            r_push_a_d <= 1'b0;
            r_push_q_d <= 1'b0;
`ifdef ALU_IO_WATCHDOG_EN
            r_wdog_cnt <= '0;
            r_rsp_err  <= 1'b0;
`endif
        end else begin
            // OUTBUS carries the pushed word one cycle after the push strobe
            r_push_a_d <= bus.pushA_in && (r_state == S_RUN);
            r_push_q_d <= bus.pushQ_in && (r_state == S_RUN);

            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op_code <= bus.req_op;
                        r_a       <= bus.req_a;
                        r_q       <= bus.req_q;
                        r_m       <= bus.req_m;
                        r_rsp_a   <= '0;
                        r_rsp_q   <= '0;
`ifdef ALU_IO_WATCHDOG_EN
                        r_rsp_err <= 1'b0;
`endif
                        r_state   <= S_START;
                    end
                end
                S_START: begin
`ifdef ALU_IO_WATCHDOG_EN
                    r_wdog_cnt <= '0;
`endif
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // The final capture coincides with END, so both share this edge
                    if (r_push_a_d) begin
                        r_rsp_a <= bus.OUTBUS;
                    end
                    if (r_push_q_d) begin
                        r_rsp_q <= bus.OUTBUS;
                    end
                    if (bus.END) begin
                        r_state <= S_RESP;
                    end
`ifdef ALU_IO_WATCHDOG_EN
                    else if (r_wdog_cnt == C_WDOG_W'(WDOG_CYCLES - 1)) begin
                        // Timeout discards any partial result
                        r_state   <= S_RESP;
                        r_rsp_err <= 1'b1;
                        r_rsp_a   <= '0;
                        r_rsp_q   <= '0;
                    end else begin
                        r_wdog_cnt <= r_wdog_cnt + C_WDOG_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_op_code <= 2'd0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operand mux: load strobes lead the datapath load edge, so this stays combinational
    always_comb begin
        w_inbus = '0;
        if (r_state == S_RUN) begin
            if (bus.loadA_in) begin
                w_inbus = r_a;
            end else if (bus.loadQ_in) begin
                w_inbus = r_q;
            end else if (bus.loadM_in) begin
                w_inbus = r_m;
            end
        end
    end

    assign bus.INBUS     = w_inbus;
    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.BEGIN     = (r_state == S_START);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.op_code   = r_op_code;
    assign bus.rsp_a     = r_rsp_a;
    assign bus.rsp_q     = r_rsp_q;

`ifdef ALU_IO_WATCHDOG_EN
    assign bus.rsp_err   = r_rsp_err;
`else
    // WDOG_CYCLES is a positive count, so this folds to a constant 0
    assign bus.rsp_err   = (WDOG_CYCLES < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_io_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_io_sequencer
//  Description : Self-checking bench for alu_io_sequencer. Plays the control
//                unit and datapath, compares responses with an arithmetic
//                model of the four ALU operations.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_io_sequencer;

    localparam int WIDTH = 8;
`ifdef ALU_IO_WATCHDOG_EN
    localparam int WDOG = 16;
`else
    localparam int WDOG = 255;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_io_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_io_sequencer #(.WIDTH(WIDTH), .WDOG_CYCLES(WDOG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result of an operation as {A, Q}
    function automatic logic [15:0] model(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] q, input logic [7:0] m);
        case (op)
            2'd0:    return {8'(a + m), 8'h00};
            2'd1:    return {8'(a - m), 8'h00};
            2'd2:    return 16'(q) * 16'(m);
            default: return {8'(q % m), 8'(q / m)};
        endcase
    endfunction

    task automatic clear_inputs();
        bus.req_valid = 1'b0; bus.req_op = 2'd0;
        bus.req_a = '0; bus.req_q = '0; bus.req_m = '0;
        bus.rsp_ready = 1'b0;
        bus.loadA_in = 1'b0; bus.loadQ_in = 1'b0; bus.loadM_in = 1'b0;
        bus.pushA_in = 1'b0; bus.pushQ_in = 1'b0; bus.END = 1'b0;
        bus.OUTBUS = '0;
    endtask

    // Offer a request in IDLE and step to the BEGIN cycle
    task automatic accept(input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] q, input logic [7:0] m);
        bus.req_op = op; bus.req_a = a; bus.req_q = q; bus.req_m = m;
        bus.req_valid = 1'b1;
        check("accept_req_ready", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        check("begin_pulse", bus.BEGIN, 1);
        check("begin_op_code", bus.op_code, op);
        check("begin_busy", bus.busy, 1);
    endtask

    // Present a push strobe, then the word on OUTBUS in the following cycle
    task automatic push_word(input bit is_a, input logic [7:0] w, input bit last);
        if (is_a) bus.pushA_in = 1'b1; else bus.pushQ_in = 1'b1;
        step();
        bus.pushA_in = 1'b0; bus.pushQ_in = 1'b0;
        bus.OUTBUS = w;
        bus.END = last;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] q,
                          input logic [7:0] m, input int hold);
        logic [15:0] exp;
        logic [15:0] dp;
        logic [7:0]  da, dq, dm;
        exp = model(op, a, q, m);
        da = 8'h00; dq = 8'h00; dm = 8'h00;
        accept(op, a, q, m);
        step();
        check("run_begin_low", bus.BEGIN, 0);
        if (op == 2'd3) begin
            // All three strobes together exercise the A > Q > M priority
            bus.loadA_in = 1'b1; bus.loadQ_in = 1'b1; bus.loadM_in = 1'b1; #1;
            check("inbus_prio_a", bus.INBUS, a); da = bus.INBUS; step();
            bus.loadA_in = 1'b0; #1;
            check("inbus_prio_q", bus.INBUS, q); dq = bus.INBUS; step();
            bus.loadQ_in = 1'b0; #1;
            check("inbus_m", bus.INBUS, m); dm = bus.INBUS; step();
            bus.loadM_in = 1'b0;
        end else begin
            if (op != 2'd2) begin
                bus.loadA_in = 1'b1; #1;
                check("inbus_a", bus.INBUS, a); da = bus.INBUS; step();
                bus.loadA_in = 1'b0;
            end else begin
                bus.loadQ_in = 1'b1; #1;
                check("inbus_q", bus.INBUS, q); dq = bus.INBUS; step();
                bus.loadQ_in = 1'b0;
            end
            repeat ($urandom_range(0, 2)) step();
            bus.loadM_in = 1'b1; #1;
            check("inbus_m", bus.INBUS, m); dm = bus.INBUS; step();
            bus.loadM_in = 1'b0;
        end
        #1;
        check("inbus_idle", bus.INBUS, 0);
        repeat ($urandom_range(0, 3)) step();
        if (op == 2'd3 && dm == 8'h00) dm = 8'h01;
        dp = model(op, da, dq, dm);
        case (op)
            2'd2: begin
                push_word(1'b1, dp[15:8], 1'b0);
                push_word(1'b0, dp[7:0], 1'b1);
            end
            2'd3: begin
                push_word(1'b0, dp[7:0], 1'b0);
                push_word(1'b1, dp[15:8], 1'b1);
            end
            default: push_word(1'b1, dp[15:8], 1'b1);
        endcase
        step();
        bus.END = 1'b0;
        bus.OUTBUS = 8'($urandom);
        check("resp_valid", bus.rsp_valid, 1);
        check("resp_a", bus.rsp_a, exp[15:8]);
        check("resp_q", bus.rsp_q, exp[7:0]);
        check("resp_err", bus.rsp_err, 0);
        check("resp_op_code", bus.op_code, op);
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            step();
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_a", bus.rsp_a, exp[15:8]);
            check("hold_q", bus.rsp_q, exp[7:0]);
            check("hold_req_ready", bus.req_ready, 0);
            check("hold_no_begin", bus.BEGIN, 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("done_rsp_valid", bus.rsp_valid, 0);
        check("done_req_ready", bus.req_ready, 1);
        check("done_op_code", bus.op_code, 0);
        check("done_busy", bus.busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 1);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_a"}, bus.rsp_a, 0);
        check({tag, "_rsp_q"}, bus.rsp_q, 0);
        check({tag, "_rsp_err"}, bus.rsp_err, 0);
        check({tag, "_begin"}, bus.BEGIN, 0);
        check({tag, "_op_code"}, bus.op_code, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] op;
        logic [7:0] a, q, m;
        clear_inputs();
        reset = 1'b0;
        step(); step();
        check_reset_values("reset");
        #2 reset = 1'b1;
        step();

        // Strobes and END outside RUN are ignored
        bus.loadA_in = 1'b1; bus.pushA_in = 1'b1; bus.END = 1'b1; bus.OUTBUS = 8'hA5; #1;
        check("idle_inbus", bus.INBUS, 0);
        step(); step();
        clear_inputs();
        check_reset_values("idle_strobes");

        // Directed operations
        run_op(2'd0, 8'h25, 8'h00, 8'h13, 0);
        run_op(2'd2, 8'h00, 8'h07, 8'h06, 0);
        run_op(2'd3, 8'h00, 8'h64, 8'h07, 0);
        run_op(2'd1, 8'h10, 8'h00, 8'h20, 5);

        // Randomised operations
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            q  = 8'($urandom);
            m  = 8'($urandom);
            if (op == 2'd3) begin
                a = 8'h00;
                m = 8'($urandom_range(1, 255));
            end
            run_op(op, a, q, m, $urandom_range(0, 2));
        end

        // Asynchronous reset in RUN right after a Q load
        accept(2'd2, 8'h00, 8'h33, 8'h05);
        step();
        bus.loadQ_in = 1'b1; #1;
        check("pre_reset_inbus", bus.INBUS, 8'h33);
        step();
        #2 reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        check("async_reset_inbus", bus.INBUS, 0);
        clear_inputs();
        step();
        #2 reset = 1'b1;
        step();
        check_reset_values("after_reset");

`ifdef ALU_IO_WATCHDOG_EN
        // END never comes: RESP with error on the 17th cycle after BEGIN
        accept(2'd0, 8'h11, 8'h00, 8'h22);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) bus.pushA_in = 1'b1;
            if (k == 2) begin bus.pushA_in = 1'b0; bus.OUTBUS = 8'h55; end
            if (k == 16) check("wdog_not_yet", bus.rsp_valid, 0);
        end
        step();
        check("wdog_rsp_valid", bus.rsp_valid, 1);
        check("wdog_rsp_err", bus.rsp_err, 1);
        check("wdog_rsp_a", bus.rsp_a, 0);
        check("wdog_rsp_q", bus.rsp_q, 0);
        bus.END = 1'b1;
        step();
        bus.END = 1'b0;
        check("wdog_late_end", bus.rsp_err, 1);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("wdog_back_idle", bus.req_ready, 1);
        step();
        run_op(2'd0, 8'h01, 8'h00, 8'h02, 0);
`else
        // Without the watchdog RUN waits for END however long it takes
        accept(2'd0, 8'h11, 8'h00, 8'h22);
        repeat (40) step();
        check("nowdog_waiting", bus.rsp_valid, 0);
        check("nowdog_busy", bus.busy, 1);
        push_word(1'b1, 8'h5A, 1'b1);
        step();
        bus.END = 1'b0;
        check("nowdog_rsp_valid", bus.rsp_valid, 1);
        check("nowdog_rsp_a", bus.rsp_a, 8'h5A);
        check("nowdog_rsp_err", bus.rsp_err, 0);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("nowdog_back_idle", bus.req_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
